// File: rtl/dp_reg_wr_queue.sv
// rtl/dp_reg_wr_queue.sv - queued masked register writes sent over a toggle seq/ack channel
// Optional merge-into-tail on a full queue: DP_REG_WR_QUEUE_COALESCE_EN
module dp_reg_wr_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     sclk,
    input  logic                     srst_n,
    input  logic [WIDTH-1:0]         wr_mask,
    input  logic [WIDTH-1:0]         wr_value,
    output logic                     wr_ready,
    output logic                     tx_seq,
    input  logic                     tx_ack,
    output logic [WIDTH-1:0]         tx_mask,
    output logic [WIDTH-1:0]         tx_value,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mem_mask_q  [DEPTH];
    logic [WIDTH-1:0]  mem_value_q [DEPTH];
    logic [AW-1:0]     head_q, tail_q, tail_last;
    logic [AW:0]       level_q, level_d;
    logic              seq_q, ovf_q;
    logic [WIDTH-1:0]  tx_mask_q, tx_value_q;
    logic              full, push_req, push, pop, merge;

    assign full      = (level_q == FULL_LEVEL);
    assign push_req  = |wr_mask;
    assign push      = push_req && !full;
    assign tail_last = tail_q - AW'(1);
    // Space freed by a pop is only visible from the next cycle, so a push never depends on the pop.
    assign pop       = (state_q == IDLE) && (level_q != '0) && (seq_q == tx_ack);
    assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);

`ifdef DP_REG_WR_QUEUE_COALESCE_EN
    assign wr_ready = 1'b1;
    assign merge    = push_req && full;
`else
    assign wr_ready = !full;
    assign merge    = 1'b0;
`endif

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_mask_q[tail_q]  <= wr_mask;
            mem_value_q[tail_q] <= wr_value;
        end else if (merge) begin
            mem_mask_q[tail_last]  <= mem_mask_q[tail_last] | wr_mask;
            mem_value_q[tail_last] <= (wr_value & wr_mask) | (mem_value_q[tail_last] & ~wr_mask);
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            seq_q      <= 1'b0;
            tx_mask_q  <= '0;
            tx_value_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                tail_q <= tail_q + AW'(1);
            end
`ifndef DP_REG_WR_QUEUE_COALESCE_EN
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_mask_q  <= mem_mask_q[head_q];
                        tx_value_q <= mem_value_q[head_q];
                        head_q     <= head_q + AW'(1);
                        seq_q      <= !seq_q;
                        state_q    <= WAIT;
                    end
                end
                // Returning to IDLE first leaves one idle cycle between transfers.
                WAIT: begin
                    if (tx_ack == seq_q) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign tx_seq   = seq_q;
    assign tx_mask  = tx_mask_q;
    assign tx_value = tx_value_q;
    assign level    = level_q;
    assign busy     = (seq_q != tx_ack);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_dp_reg_wr_queue.sv
// tb/tb_dp_reg_wr_queue.sv - scoreboard bench for dp_reg_wr_queue with a queue-based reference model
module tb_dp_reg_wr_queue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       sclk = 1'b0;
    logic       srst_n = 1'b0;
    logic [7:0] wr_mask = 8'h00;
    logic [7:0] wr_value = 8'h00;
    logic       tx_ack = 1'b0;
    logic       wr_ready, tx_seq, busy, overflow;
    logic [7:0] tx_mask, tx_value;
    logic [2:0] level;

    always #5 sclk = ~sclk;

    dp_reg_wr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sclk(sclk), .srst_n(srst_n),
        .wr_mask(wr_mask), .wr_value(wr_value), .wr_ready(wr_ready),
        .tx_seq(tx_seq), .tx_ack(tx_ack),
        .tx_mask(tx_mask), .tx_value(tx_value),
        .level(level), .busy(busy), .overflow(overflow)
    );

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] v;
    } ent_t;

    ent_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    bit         ovf_m = 0;
    bit         pushed_now = 0;
    bit         in_wait_m = 0;
    bit         ack_hold = 0;
    logic       exp_seq = 1'b0;
    logic [7:0] exp_mask = 8'h00;
    logic [7:0] exp_value = 8'h00;
    int         ack_cnt = 0;
    int         ack_lat = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus; the remote end echoes tx_seq after ack_lat cycles unless held.
    task automatic step(input logic [7:0] m, input logic [7:0] v);
        ent_t t;
        @(negedge sclk);
        if (!ack_hold && (tx_seq !== tx_ack)) begin
            if (ack_cnt >= ack_lat) begin
                tx_ack  = tx_seq;
                ack_cnt = 0;
                ack_lat = $urandom_range(0, 3);
            end else begin
                ack_cnt++;
            end
        end
        wr_mask  = m;
        wr_value = v;
        if (m != 8'h00) begin
            if (sb.size() < DEPTH) begin
                sb.push_back(ent_t'({m, v}));
                pushed_now = 1;
            end else begin
`ifdef DP_REG_WR_QUEUE_COALESCE_EN
                t = sb[sb.size()-1];
                t.v = (v & m) | (t.v & ~m);
                t.m = t.m | m;
                sb[sb.size()-1] = t;
`else
                ovf_m = 1;
`endif
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(8'h00, 8'h00);
            if (sb.size() == 0 && !in_wait_m) done = 1;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    ent_t e;
    bit   pre_busy, exp_launch;
    int   pre_level;

    // Monitor: rules of the channel applied one cycle at a time, after each edge settles.
    always @(posedge sclk) begin
        #1;
        if (!srst_n) begin
            exp_seq = 1'b0; exp_mask = 8'h00; exp_value = 8'h00;
            in_wait_m = 0; pushed_now = 0;
            chk("rst_tx_seq", 32'(tx_seq), 32'd0);
            chk("rst_tx_mask", 32'(tx_mask), 32'd0);
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        end else begin
            pre_busy   = (exp_seq != tx_ack);
            pre_level  = sb.size() - int'(pushed_now);
            exp_launch = (pre_level > 0) && !pre_busy && !in_wait_m;
            if (exp_launch) begin
                e = sb.pop_front();
                exp_seq   = ~exp_seq;
                exp_mask  = e.m;
                exp_value = e.v;
                in_wait_m = 1;
            end else if (in_wait_m && !pre_busy) begin
                in_wait_m = 0;
            end
            pushed_now = 0;
            chk("tx_seq", 32'(tx_seq), 32'(exp_seq));
            chk("tx_mask", 32'(tx_mask), 32'(exp_mask));
            chk("tx_value", 32'(tx_value), 32'(exp_value));
            chk("level", 32'(level), sb.size());
            chk("overflow", 32'(overflow), 32'(ovf_m));
            chk("busy", 32'(busy), 32'(exp_seq != tx_ack));
`ifdef DP_REG_WR_QUEUE_COALESCE_EN
            chk("wr_ready", 32'(wr_ready), 32'd1);
`else
            chk("wr_ready", 32'(wr_ready), 32'(sb.size() != DEPTH));
`endif
        end
    end

    initial begin
        logic [7:0] m;
        srst_n = 1'b0; wr_mask = 8'hFF; tx_ack = 1'b0;
        repeat (3) @(negedge sclk);
        srst_n = 1'b1; wr_mask = 8'h00;
        repeat (3) step(8'h00, 8'h00);

        ack_lat = 2;
        step(8'h0F, 8'hA5);
        repeat (8) step(8'h00, 8'h00);

        ack_hold = 1;
        for (int i = 1; i <= 6; i++) step(8'hFF, 8'(i));
        repeat (3) step(8'h00, 8'h00);
        ack_hold = 0;
        drain();

        repeat (4) step(8'h00, 8'hFF);

        ack_hold = 1;
        step(8'hFF, 8'h11); step(8'hFF, 8'h22); step(8'hFF, 8'h33);
        step(8'h00, 8'h00);
        @(negedge sclk);
        tx_ack = 1'b1; srst_n = 1'b0; wr_mask = 8'h00;
        sb.delete(); ovf_m = 0; pushed_now = 0;
        @(negedge sclk);
        srst_n = 1'b1;
        step(8'h00, 8'h00);
        chk("post_rst_busy", 32'(busy), 32'd1);
        step(8'h3C, 8'h77);
        repeat (3) step(8'h00, 8'h00);
        ack_hold = 0;
        drain();

        ack_hold = 1;
        step(8'hFF, 8'h01); step(8'hFF, 8'h02); step(8'hFF, 8'h03); step(8'hFF, 8'h04);
        step(8'h0F, 8'h05);
        step(8'hF0, 8'h30);
        step(8'h00, 8'h00);
        chk("full_level", 32'(level), 32'd4);
        ack_hold = 0;
        drain();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) ack_hold = !ack_hold;
            m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            step(m, 8'($urandom));
        end
        ack_hold = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
